// File: rtl/irrigacao_pkg.sv
// Shared definitions for the multi-zone irrigation controller.
//   - state encodings ENCHER..LIMPAR and the width of the estado output
//   - zone watering mode decode (spray, drip, or spray followed by drip)
package irrigacao_pkg;

  localparam int ESTADO_W = 3;

  localparam logic [ESTADO_W-1:0] ENCHER   = 3'd0;
  localparam logic [ESTADO_W-1:0] AVALIAR  = 3'd1;
  localparam logic [ESTADO_W-1:0] ASPERGIR = 3'd2;
  localparam logic [ESTADO_W-1:0] GOTEJAR  = 3'd3;
  localparam logic [ESTADO_W-1:0] LIMPAR   = 3'd4;

  typedef enum logic [1:0] {
    MODO_ASPERSAO = 2'd0,
    MODO_GOTEJO   = 2'd1,
    MODO_ESPECIAL = 2'd2
  } modo_t;

  // Dry air -> spray; humid and hot -> drip; humid and cool -> spray then drip.
  function automatic modo_t decodifica_modo(input logic ua, input logic t);
    if (!ua) begin
      return MODO_ASPERSAO;
    end else if (t) begin
      return MODO_GOTEJO;
    end else begin
      return MODO_ESPECIAL;
    end
  endfunction

endpackage

// File: rtl/seletor_zona_rr.sv
// Combinational round-robin finder: first zone with dry soil (us[z]=0),
// scanning from ponteiro upward and wrapping.
//   us       : soil humidity per zone, 1 = moist
//   ponteiro : zone where the scan starts
//   achou    : a needy zone exists
//   zona     : index of that zone (ponteiro when none found)
module seletor_zona_rr #(
  parameter int NUM_ZONES = 4,
  parameter int ZW        = 2
) (
  input  logic [NUM_ZONES-1:0] us,
  input  logic [ZW-1:0]        ponteiro,
  output logic                 achou,
  output logic [ZW-1:0]        zona
);

  always_comb begin
    int          idx;
    logic [ZW-1:0] idx_z;
    achou = 1'b0;
    zona  = ponteiro;
    idx   = 0;
    idx_z = '0;
    for (int k = 0; k < NUM_ZONES; k++) begin
      idx   = (int'(ponteiro) + k) % NUM_ZONES;
      idx_z = ZW'(idx);
      if (!achou && !us[idx_z]) begin
        achou = 1'b1;
        zona  = idx_z;
      end
    end
  end

endmodule

// File: rtl/irrigacao_multizona.sv
// Multi-zone irrigation controller: one shared tank (fill / flush) and
// NUM_ZONES zones, each with a sprinkler and a drip valve, served round-robin.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   tick                : one-cycle timebase pulse advancing phase counters
//   botao               : manual abort back to ENCHER
//   tanque_cheio/vazio  : tank level sensors
//   us                  : soil humidity per zone (1 = moist)
//   ua, t               : air humidity high, temperature high
//   estado, zona        : current state and zone being served
//   valvula_*           : Moore-decoded valve drives
//   caso_esp            : spray-then-drip flag latched for the current cycle
module irrigacao_multizona
  import irrigacao_pkg::*;
#(
  parameter int NUM_ZONES      = 4,
  parameter int ZW             = 2,
  parameter int CNT_W          = 8,
  parameter int SPRAY_TICKS    = 10,
  parameter int DRIP_TICKS     = 20,
  parameter int ESP_DRIP_TICKS = 15,
  parameter int CLEAN_TICKS    = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 botao,
  input  logic                 tanque_cheio,
  input  logic                 tanque_vazio,
  input  logic [NUM_ZONES-1:0] us,
  input  logic                 ua,
  input  logic                 t,
  output logic [ESTADO_W-1:0]  estado,
  output logic [ZW-1:0]        zona,
  output logic                 valvula_entrada,
  output logic [NUM_ZONES-1:0] valvula_aspersor,
  output logic [NUM_ZONES-1:0] valvula_gotejo,
  output logic                 valvula_limpeza,
  output logic                 caso_esp
);

  logic [ESTADO_W-1:0] estado_q, estado_d;
  logic [ZW-1:0]       zona_q, zona_d;
  logic [ZW-1:0]       ponteiro_q, ponteiro_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                caso_q, caso_d;

  logic                achou;
  logic [ZW-1:0]       zona_sel;
  modo_t               modo;
  logic                encerra_cedo;
  logic [CNT_W-1:0]    ultimo_gotejo;

  seletor_zona_rr #(
    .NUM_ZONES (NUM_ZONES),
    .ZW        (ZW)
  ) u_seletor (
    .us       (us),
    .ponteiro (ponteiro_q),
    .achou    (achou),
    .zona     (zona_sel)
  );

  always_comb begin
    estado_d   = estado_q;
    zona_d     = zona_q;
    ponteiro_d = ponteiro_q;
    caso_d     = caso_q;
    modo          = decodifica_modo(ua, t);
    // Zone got wet or tank ran dry: abandon the phase, even a pending drip.
    encerra_cedo  = us[zona_q] | tanque_vazio;
    ultimo_gotejo = caso_q ? CNT_W'(ESP_DRIP_TICKS - 1) : CNT_W'(DRIP_TICKS - 1);

    case (estado_q)
      ENCHER: begin
        if (tanque_cheio) estado_d = AVALIAR;
      end
      AVALIAR: begin
        if (achou) begin
          zona_d   = zona_sel;
          caso_d   = (modo == MODO_ESPECIAL);
          estado_d = (modo == MODO_GOTEJO) ? GOTEJAR : ASPERGIR;
        end
      end
      ASPERGIR: begin
        if (encerra_cedo) begin
          estado_d = LIMPAR;
        end else if (tick && cnt_q == CNT_W'(SPRAY_TICKS - 1)) begin
          estado_d = caso_q ? GOTEJAR : LIMPAR;
        end
      end
      GOTEJAR: begin
        if (encerra_cedo || (tick && cnt_q == ultimo_gotejo)) estado_d = LIMPAR;
      end
      LIMPAR: begin
        if (tick && cnt_q == CNT_W'(CLEAN_TICKS - 1)) begin
          ponteiro_d = (zona_q == ZW'(NUM_ZONES - 1)) ? '0 : zona_q + 1'b1;
          caso_d     = 1'b0;
          estado_d   = tanque_vazio ? ENCHER : AVALIAR;
        end
      end
      default: estado_d = ENCHER;
    endcase

    // Manual abort wins over everything, but keeps zone and pointer.
    if (botao) begin
      estado_d   = ENCHER;
      zona_d     = zona_q;
      ponteiro_d = ponteiro_q;
      caso_d     = 1'b0;
    end

    // Counter restarts on every state entry so each phase counts from zero.
    if (botao || estado_d != estado_q) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= ENCHER;
      zona_q     <= '0;
      ponteiro_q <= '0;
      cnt_q      <= '0;
      caso_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      zona_q     <= zona_d;
      ponteiro_q <= ponteiro_d;
      cnt_q      <= cnt_d;
      caso_q     <= caso_d;
    end
  end

  always_comb begin
    valvula_aspersor = '0;
    valvula_gotejo   = '0;
    if (estado_q == ASPERGIR) valvula_aspersor[zona_q] = 1'b1;
    if (estado_q == GOTEJAR)  valvula_gotejo[zona_q]   = 1'b1;
  end

  assign estado          = estado_q;
  assign zona            = zona_q;
  assign caso_esp        = caso_q;
  assign valvula_entrada = (estado_q == ENCHER);
  assign valvula_limpeza = (estado_q == LIMPAR);

endmodule
